ram_arbiter: RTL

Two-client front end placed directly upstream of the embedded SDRAM controller. It accepts single-word read requests from the video fetch client (port A) and single-word read or write requests from the CPU client (port B). It serialises them into the controller's pulse-request / pulse-completion interface, with exactly one transaction outstanding at a time. Port A has priority, bounded by an anti-starvation counter. A watchdog recovers the block if the controller never completes a transaction.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_request_slot.sv | 56 +++++
 rtl/ram_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the two-client SDRAM arbiter: controller-facing widths
// and the arbiter state encoding.
package ram_pkg;

  localparam int unsigned ADDR_WIDTH = 23;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MASK_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    WAIT_WR = 2'd2
  } state_t;

endpackage

// File: rtl/ram_request_slot.sv
// One-deep pending request register for a single client port: captures a strobe
// when empty, holds it until the arbiter clears it on completion or abort.
module ram_request_slot
  import ram_pkg::*;
#(
  parameter int unsigned AW = ADDR_WIDTH,
  parameter int unsigned DW = DATA_WIDTH,
  parameter int unsigned MW = MASK_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rd_strobe,
  input  logic          i_wr_strobe,
  input  logic [AW-1:0] i_address,
  input  logic [DW-1:0] i_wr_data,
  input  logic [MW-1:0] i_wr_mask,
  input  logic          i_clear,
  output logic          o_valid,
  output logic          o_is_write,
  output logic [AW-1:0] o_address,
  output logic [DW-1:0] o_wr_data,
  output logic [MW-1:0] o_wr_mask
);

  logic          r_valid;
  logic          r_is_write;
  logic [AW-1:0] r_address;
  logic [DW-1:0] r_wr_data;
  logic [MW-1:0] r_wr_mask;

  // A strobe is only taken while empty; strobes arriving while busy are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_is_write <= 1'b0;
      r_address  <= '0;
      r_wr_data  <= '0;
      r_wr_mask  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (!r_valid && (i_rd_strobe || i_wr_strobe)) begin
      r_valid    <= 1'b1;
      r_is_write <= i_wr_strobe;
      r_address  <= i_address;
      r_wr_data  <= i_wr_data;
      r_wr_mask  <= i_wr_mask;
    end
  end

  assign o_valid    = r_valid;
  assign o_is_write = r_is_write;
  assign o_address  = r_address;
  assign o_wr_data  = r_wr_data;
  assign o_wr_mask  = r_wr_mask;

endmodule

// File: rtl/ram_arbiter.sv
// Two-client front end for the SDRAM controller: serialises port A reads and
// port B reads/writes with one transaction in flight, A-priority with a streak limit.
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH        = ram_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH        = ram_pkg::DATA_WIDTH,
  parameter int unsigned MASK_WIDTH        = ram_pkg::MASK_WIDTH,
  parameter int unsigned A_MAX_CONSECUTIVE = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_rd_request,
  input  logic [ADDR_WIDTH-1:0] a_rd_address,
  output logic                  a_busy,
  output logic                  a_rd_available,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic                  b_rd_request,
  input  logic                  b_wr_request,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  input  logic [MASK_WIDTH-1:0] b_wr_mask,
  output logic                  b_busy,
  output logic                  b_rd_available,
  output logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  b_wr_done,
  output logic                  rd_request,
  output logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  rd_available,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_request,
  input  logic                  wr_done,
  output logic [MASK_WIDTH-1:0] wr_mask,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  timeout_error
);

  import ram_pkg::*;

  localparam int unsigned WDOG_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned STREAK_W = $clog2(A_MAX_CONSECUTIVE + 1);

  state_t r_state;
  state_t w_next_state;

  logic                  w_a_valid, w_a_is_write, w_a_clear;
  logic [ADDR_WIDTH-1:0] w_a_address;
  logic [DATA_WIDTH-1:0] w_a_wr_data;
  logic [MASK_WIDTH-1:0] w_a_wr_mask;

  logic                  w_b_valid, w_b_is_write, w_b_clear;
  logic [ADDR_WIDTH-1:0] w_b_address;
  logic [DATA_WIDTH-1:0] w_b_wr_data;
  logic [MASK_WIDTH-1:0] w_b_wr_mask;

  logic                  w_issue, w_issue_b;
  logic                  w_rd_done, w_wr_done, w_abort;
  logic                  w_wdog_expired, w_streak_full;
  logic                  w_sel_is_write;
  logic [ADDR_WIDTH-1:0] w_sel_address;
  logic [DATA_WIDTH-1:0] w_sel_wr_data;
  logic [MASK_WIDTH-1:0] w_sel_wr_mask;

  logic                  r_grant_b;
  logic [WDOG_W-1:0]     r_wdog;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_cooldown;
  logic                  r_rd_request, r_wr_request;
  logic [ADDR_WIDTH-1:0] r_rd_address, r_wr_address;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [MASK_WIDTH-1:0] r_wr_mask;
  logic                  r_a_rd_available, r_b_rd_available, r_b_wr_done;
  logic [DATA_WIDTH-1:0] r_a_rd_data, r_b_rd_data;
  logic                  r_timeout_error;

  ram_request_slot #(
    .AW (ADDR_WIDTH),
    .DW (DATA_WIDTH),
    .MW (MASK_WIDTH)
  ) u_slot_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_strobe (a_rd_request),
    .i_wr_strobe (1'b0),
    .i_address   (a_rd_address),
    .i_wr_data   ('0),
    .i_wr_mask   ('0),
    .i_clear     (w_a_clear),
    .o_valid     (w_a_valid),
    .o_is_write  (w_a_is_write),
    .o_address   (w_a_address),
    .o_wr_data   (w_a_wr_data),
    .o_wr_mask   (w_a_wr_mask)
  );

  ram_request_slot #(
    .AW (ADDR_WIDTH),
    .DW (DATA_WIDTH),
    .MW (MASK_WIDTH)
  ) u_slot_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_strobe (b_rd_request & ~b_wr_request),
    .i_wr_strobe (b_wr_request),
    .i_address   (b_address),
    .i_wr_data   (b_wr_data),
    .i_wr_mask   (b_wr_mask),
    .i_clear     (w_b_clear),
    .o_valid     (w_b_valid),
    .o_is_write  (w_b_is_write),
    .o_address   (w_b_address),
    .o_wr_data   (w_b_wr_data),
    .o_wr_mask   (w_b_wr_mask)
  );

  assign w_wdog_expired = (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign w_streak_full  = (r_streak == STREAK_W'(A_MAX_CONSECUTIVE));

  assign w_sel_is_write = w_issue_b ? w_b_is_write : w_a_is_write;
  assign w_sel_address  = w_issue_b ? w_b_address  : w_a_address;
  assign w_sel_wr_data  = w_issue_b ? w_b_wr_data  : w_a_wr_data;
  assign w_sel_wr_mask  = w_issue_b ? w_b_wr_mask  : w_a_wr_mask;

  assign w_a_clear = (w_rd_done | w_wr_done | w_abort) & ~r_grant_b;
  assign w_b_clear = (w_rd_done | w_wr_done | w_abort) &  r_grant_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // IDLE skips the cycle right after a completion so the client just served
  // can re-queue; otherwise A could never win twice and the streak limit is moot.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_issue_b    = 1'b0;
    w_rd_done    = 1'b0;
    w_wr_done    = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_cooldown) begin
          if (w_a_valid && !(w_b_valid && w_streak_full)) begin
            w_issue = 1'b1;
          end else if (w_b_valid) begin
            w_issue   = 1'b1;
            w_issue_b = 1'b1;
          end
        end
        if (w_issue) begin
          w_next_state = w_sel_is_write ? WAIT_WR : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (rd_available) begin
          w_rd_done    = 1'b1;
          w_next_state = IDLE;
        end else if (w_wdog_expired) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end
      end
      WAIT_WR: begin
        if (wr_done) begin
          w_wr_done    = 1'b1;
          w_next_state = IDLE;
        end else if (w_wdog_expired) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_b        <= 1'b0;
      r_wdog           <= '0;
      r_streak         <= '0;
      r_cooldown       <= 1'b0;
      r_rd_request     <= 1'b0;
      r_wr_request     <= 1'b0;
      r_rd_address     <= '0;
      r_wr_address     <= '0;
      r_wr_data        <= '0;
      r_wr_mask        <= '0;
      r_a_rd_available <= 1'b0;
      r_b_rd_available <= 1'b0;
      r_b_wr_done      <= 1'b0;
      r_a_rd_data      <= '0;
      r_b_rd_data      <= '0;
      r_timeout_error  <= 1'b0;
    end else begin
      r_rd_request     <= w_issue & ~w_sel_is_write;
      r_wr_request     <= w_issue &  w_sel_is_write;
      r_a_rd_available <= w_rd_done & ~r_grant_b;
      r_b_rd_available <= w_rd_done &  r_grant_b;
      r_b_wr_done      <= w_wr_done &  r_grant_b;
      r_cooldown       <= w_rd_done | w_wr_done;

      if (w_issue) begin
        r_grant_b <= w_issue_b;
        r_wdog    <= '0;
        if (w_sel_is_write) begin
          r_wr_address <= w_sel_address;
          r_wr_data    <= w_sel_wr_data;
          r_wr_mask    <= w_sel_wr_mask;
        end else begin
          r_rd_address <= w_sel_address;
        end
        if (!w_issue_b && w_b_valid) begin
          r_streak <= r_streak + 1'b1;
        end else begin
          r_streak <= '0;
        end
      end else if (r_state != IDLE) begin
        r_wdog <= r_wdog + 1'b1;
      end

      if (w_rd_done) begin
        if (r_grant_b) begin
          r_b_rd_data <= rd_data;
        end else begin
          r_a_rd_data <= rd_data;
        end
      end

      if (w_abort) begin
        r_timeout_error <= 1'b1;
      end
    end
  end

  assign a_busy         = w_a_valid;
  assign b_busy         = w_b_valid;
  assign a_rd_available = r_a_rd_available;
  assign a_rd_data      = r_a_rd_data;
  assign b_rd_available = r_b_rd_available;
  assign b_rd_data      = r_b_rd_data;
  assign b_wr_done      = r_b_wr_done;
  assign rd_request     = r_rd_request;
  assign rd_address     = r_rd_address;
  assign wr_request     = r_wr_request;
  assign wr_address     = r_wr_address;
  assign wr_data        = r_wr_data;
  assign wr_mask        = r_wr_mask;
  assign timeout_error  = r_timeout_error;

endmodule
